// File: rtl/ecc_72_scrub_ctrl.sv
// Background SECDED scrubber: walks memory, corrects single-bit errors in place, logs double-bit errors.
// Optional automatic passes after an idle interval when ECC_SCRUB_AUTO_EN is defined.
`timescale 1ns/1ps

module ecc_72_top (
  input  logic        bypass,
  input  logic [71:0] data_in,
  input  logic [7:0]  parity_in,
  output logic [71:0] data_out,
  output logic [7:0]  parity_out,
  output logic        sbit_err,
  output logic        dbit_err
);
  // Extended Hamming code: data bit i sits at the i-th non-power-of-two codeword position,
  // parity[6:0] are the Hamming checks and parity[7] is overall parity over data and checks.
  function automatic int data_pos(input int idx);
    int n;
    int p;
    n = -1;
    p = 0;
    for (int q = 1; q < 128; q++) begin
      if ((q & (q - 1)) != 0) begin
        n++;
        if (n == idx && p == 0) p = q;
      end
    end
    return p;
  endfunction

  function automatic logic [71:0] row_mask(input int j);
    logic [71:0] m;
    int p;
    m = '0;
    for (int i = 0; i < 72; i++) begin
      p = data_pos(i);
      m[i] = p[j];
    end
    return m;
  endfunction

  logic [6:0]  chk_in;
  logic [6:0]  chk_out;
  logic [6:0]  syndrome;
  logic [71:0] flip;
  logic        overall;
  logic        syn_pow2;
  logic        data_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_chk
      localparam logic [71:0] MASK = row_mask(gi);
      assign chk_in[gi]  = ^(data_in & MASK);
      assign chk_out[gi] = ^(data_out & MASK);
    end
    for (gi = 0; gi < 72; gi++) begin : g_flip
      localparam logic [6:0] POS = 7'(data_pos(gi));
      assign flip[gi] = (syndrome == POS);
    end
  endgenerate

  assign syndrome = chk_in ^ parity_in[6:0];
  assign overall  = ^{data_in, parity_in};
  assign syn_pow2 = ((syndrome & (syndrome - 7'd1)) == 7'd0);
  assign data_hit = |flip;

  // Odd overall parity with a syndrome that matches no codeword position is a multi-bit error.
  assign sbit_err   = !bypass && overall && (syn_pow2 || data_hit);
  assign dbit_err   = !bypass && ((!overall && syndrome != 7'd0) || (overall && !syn_pow2 && !data_hit));
  assign data_out   = (bypass || !overall) ? data_in : (data_in ^ flip);
  assign parity_out = bypass ? parity_in : {^{data_out, chk_out}, chk_out};
endmodule

module ecc_72_scrub_ctrl #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DEPTH          = 256,
  parameter int DATA_WIDTH     = 72,
  parameter int PARITY_WIDTH   = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int SCRUB_INTERVAL = 65536
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    clr_cnt,
  output logic                    mem_req,
  input  logic                    mem_gnt,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [PARITY_WIDTH-1:0] mem_wparity,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic [PARITY_WIDTH-1:0] mem_rparity,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    sbe_cnt,
  output logic [CNT_WIDTH-1:0]    dbe_cnt,
  output logic [ADDR_WIDTH-1:0]   dbe_addr,
  output logic                    dbe_irq
);
  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_CHECK, S_WR_REQ, S_NEXT, S_DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg, wdata_reg;
  logic [PARITY_WIDTH-1:0] rparity_reg, wparity_reg;
  logic [CNT_WIDTH-1:0]    sbe_cnt_reg, dbe_cnt_reg;
  logic [ADDR_WIDTH-1:0]   dbe_addr_reg;
  logic [DATA_WIDTH-1:0]   corr_data;
  logic [PARITY_WIDTH-1:0] corr_parity;
  logic                    sbit_err, dbit_err;
  logic                    auto_start;
  logic                    last_addr;

  ecc_72_top u_ecc (
    .bypass     (1'b0),
    .data_in    (rdata_reg),
    .parity_in  (rparity_reg),
    .data_out   (corr_data),
    .parity_out (corr_parity),
    .sbit_err   (sbit_err),
    .dbit_err   (dbit_err)
  );

`ifdef ECC_SCRUB_AUTO_EN
  localparam int IW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  logic [IW-1:0] interval_reg;

  always_ff @(posedge clk) begin
    if (rst || state_next != S_IDLE) interval_reg <= '0;
    else if (interval_reg != IW'(SCRUB_INTERVAL - 1)) interval_reg <= interval_reg + 1'b1;
  end

  assign auto_start = (state_reg == S_IDLE) && (interval_reg == IW'(SCRUB_INTERVAL - 1));
`else
  assign auto_start = 1'b0;
`endif

  assign last_addr = (addr_reg == ADDR_WIDTH'(DEPTH - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start || auto_start) state_next = S_RD_REQ;
      S_RD_REQ:  if (mem_gnt) state_next = S_RD_WAIT;
                 else if (abort) state_next = S_IDLE;
      S_RD_WAIT: if (mem_rvalid) state_next = S_CHECK;
      S_CHECK:   state_next = sbit_err ? S_WR_REQ : S_NEXT;
      S_WR_REQ:  if (mem_gnt) state_next = S_NEXT;
      S_NEXT:    if (abort) state_next = S_IDLE;
                 else if (last_addr) state_next = S_DONE;
                 else state_next = S_RD_REQ;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      rdata_reg    <= '0;
      rparity_reg  <= '0;
      wdata_reg    <= '0;
      wparity_reg  <= '0;
      sbe_cnt_reg  <= '0;
      dbe_cnt_reg  <= '0;
      dbe_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && state_next == S_RD_REQ) addr_reg <= '0;
      else if (state_reg == S_NEXT && state_next == S_RD_REQ) addr_reg <= addr_reg + 1'b1;
      if (state_reg == S_RD_WAIT && mem_rvalid) begin
        rdata_reg   <= mem_rdata;
        rparity_reg <= mem_rparity;
      end
      if (state_reg == S_CHECK) begin
        wdata_reg   <= corr_data;
        wparity_reg <= corr_parity;
        if (dbit_err) dbe_addr_reg <= addr_reg;
      end
      // A clear in the same cycle as an error event takes priority over the increment.
      if (clr_cnt) begin
        sbe_cnt_reg <= '0;
        dbe_cnt_reg <= '0;
      end else if (state_reg == S_CHECK) begin
        if (sbit_err && sbe_cnt_reg != '1) sbe_cnt_reg <= sbe_cnt_reg + 1'b1;
        if (dbit_err && dbe_cnt_reg != '1) dbe_cnt_reg <= dbe_cnt_reg + 1'b1;
      end
    end
  end

  assign mem_req     = (state_reg == S_RD_REQ) || (state_reg == S_WR_REQ);
  assign mem_we      = (state_reg == S_WR_REQ);
  assign mem_addr    = addr_reg;
  assign mem_wdata   = wdata_reg;
  assign mem_wparity = wparity_reg;
  assign busy        = (state_reg != S_IDLE);
  assign done        = (state_reg == S_DONE);
  assign dbe_irq     = (state_reg == S_CHECK) && dbit_err;
  assign sbe_cnt     = sbe_cnt_reg;
  assign dbe_cnt     = dbe_cnt_reg;
  assign dbe_addr    = dbe_addr_reg;
endmodule

// File: tb/tb_ecc_72_scrub_ctrl.sv
// Scoreboard bench for ecc_72_scrub_ctrl: random-stall memory model, expected-event queue, separate monitor.
`timescale 1ns/1ps

module tb_ecc_72_scrub_ctrl;
  localparam int AW = 4;
  localparam int NW = 16;
  localparam int CW = 4;
  localparam int K_RD = 0, K_WR = 1, K_DBE = 2, K_DONE = 3;

  typedef struct {
    int          kind;
    int          addr;
    logic [71:0] d;
    logic [7:0]  p;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst, start, abort, clr_cnt;
  logic          mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [AW-1:0] mem_addr, dbe_addr;
  logic [71:0]   mem_wdata, mem_rdata;
  logic [7:0]    mem_wparity, mem_rparity;
  logic          busy, done, dbe_irq;
  logic [CW-1:0] sbe_cnt, dbe_cnt;

  ecc_72_scrub_ctrl #(.ADDR_WIDTH(AW), .DEPTH(NW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .clr_cnt(clr_cnt),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wparity(mem_wparity), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_rparity(mem_rparity), .busy(busy), .done(done),
    .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt), .dbe_addr(dbe_addr), .dbe_irq(dbe_irq)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  ev_t         exp_q[$];
  logic [71:0] mem_d[NW], orig_d[NW];
  logic [7:0]  mem_p[NW], orig_p[NW];
  int          rd_seen = 0, wr_seen = 0, done_seen = 0;
  bit          mon_en = 1'b1;
  bit          stall_armed = 1'b0, clr_armed = 1'b0;
  int          clr_addr = -1;
  int          model_sbe = 0, model_dbe = 0, model_dbe_addr = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference encoder: data bits fill the non-power-of-two positions 3,5,6,7,9,...; each Hamming
  // check is the XOR of the positions of the set data bits; bit 7 makes the whole word even.
  function automatic logic [7:0] encode(input logic [71:0] d);
    logic [6:0] c = '0;
    int n = 0;
    for (int q = 1; q < 128 && n < 72; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (d[n]) c ^= 7'(q);
        n++;
      end
    end
    return {^{d, c}, c};
  endfunction

  // Memory model: random grant stalls, read data 1-3 cycles after the grant.
  initial begin : memory_model
    bit          xfer_q = 1'b0, we_q = 1'b0, rd_pend = 1'b0, clr_next = 1'b0, gnt_v;
    logic [AW-1:0] a_q = '0, rd_a = '0;
    logic [71:0] wd_q = '0;
    logic [7:0]  wp_q = '0;
    int          rd_left = 0, stall_left = 0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rparity = '0;
    abort = 1'b0; clr_cnt = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      clr_cnt = 1'b0;
      if (rst) begin
        xfer_q = 1'b0; rd_pend = 1'b0; clr_next = 1'b0; stall_left = 0;
        mem_gnt = 1'b0; abort = 1'b0;
      end else begin
        if (clr_next) begin clr_cnt = 1'b1; clr_next = 1'b0; end
        if (xfer_q) begin
          if (we_q) begin mem_d[a_q] = wd_q; mem_p[a_q] = wp_q; end
          else begin rd_pend = 1'b1; rd_left = $urandom_range(1, 3); rd_a = a_q; end
        end
        if (rd_pend) begin
          rd_left--;
          if (rd_left == 0) begin
            rd_pend = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata = mem_d[rd_a];
            mem_rparity = mem_p[rd_a];
            if (clr_armed && int'(rd_a) == clr_addr) begin clr_next = 1'b1; clr_armed = 1'b0; end
          end
        end
        if (!busy) abort = 1'b0;
        gnt_v = 1'b0;
        if (mem_req) begin
          if (mem_we && stall_armed) begin stall_armed = 1'b0; stall_left = 20; abort = 1'b1; end
          if (stall_left > 0) stall_left--;
          else gnt_v = ($urandom_range(0, 3) != 0);
        end
        mem_gnt = gnt_v;
        xfer_q = mem_req && gnt_v;
        we_q = mem_we; a_q = mem_addr; wd_q = mem_wdata; wp_q = mem_wparity;
      end
    end
  end

  task automatic expect_event(input int kind, input int addr, input logic [71:0] d, input logic [7:0] p);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL unexpected_event: got kind %0d addr %0d expected none", kind, addr);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 96'(kind), 96'(e.kind));
      if (kind != K_DONE) check("event_addr", 96'(addr), 96'(e.addr));
      if (kind == K_WR) begin
        check("wr_data", 96'(d), 96'(e.d));
        check("wr_parity", 96'(p), 96'(e.p));
      end
    end
  endtask

  // Monitor: pops the scoreboard on every transfer, dbe_irq and done; checks handshake stability.
  initial begin : monitor
    bit          have_stall = 1'b0, have_xfer = 1'b0;
    logic [85:0] prev = '0;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        have_stall = 1'b0; have_xfer = 1'b0;
      end else begin
        if (have_stall) check("hold_stable", 96'({mem_req, mem_we, mem_addr, mem_wdata, mem_wparity}), 96'(prev));
        if (have_xfer) check("req_drop", 96'(mem_req), 96'(0));
        have_stall = mem_req && !mem_gnt;
        have_xfer = mem_req && mem_gnt;
        prev = {mem_req, mem_we, mem_addr, mem_wdata, mem_wparity};
        if (mem_req && mem_gnt) begin
          $display("[TB] %s addr=%0d data=%h parity=%h", mem_we ? "write" : "read ", mem_addr,
                   mem_wdata, mem_wparity);
          if (mem_we) wr_seen++; else rd_seen++;
          expect_event(mem_we ? K_WR : K_RD, int'(mem_addr), mem_wdata, mem_wparity);
        end
        if (dbe_irq) begin
          $display("[TB] dbe_irq addr=%0d", mem_addr);
          expect_event(K_DBE, int'(mem_addr), '0, '0);
        end
        if (done) begin
          $display("[TB] done");
          done_seen++;
          expect_event(K_DONE, 0, '0, '0);
        end
      end
    end
  end

  task automatic init_mem();
    for (int a = 0; a < NW; a++) begin
      orig_d[a] = {$urandom(), $urandom(), $urandom()};
      orig_p[a] = encode(orig_d[a]);
      mem_d[a] = orig_d[a];
      mem_p[a] = orig_p[a];
    end
  endtask

  // Flip codeword bit b of word a: 0..71 are data bits, 72..79 are parity bits.
  task automatic flip_bit(input int a, input int b);
    if (b < 72) mem_d[a][b] = ~mem_d[a][b];
    else mem_p[a][b - 72] = ~mem_p[a][b - 72];
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(name, 96'(busy), 96'(0));
  endtask

  // One pass: the expected event list comes from how many bits of each word differ from its clean copy.
  task automatic run_pass(input string tag, input int abort_at, input int clr_at);
    int rd0 = rd_seen, wr0 = wr_seen, dn0 = done_seen;
    int exp_rd = 0, exp_wr = 0, exp_dn = 0, nerr;
    ev_t e;
    for (int a = 0; a < NW; a++) begin
      e = '{K_RD, a, '0, '0};
      exp_q.push_back(e);
      exp_rd++;
      nerr = $countones(mem_d[a] ^ orig_d[a]) + $countones(mem_p[a] ^ orig_p[a]);
      if (nerr == 1) begin
        e = '{K_WR, a, orig_d[a], orig_p[a]};
        exp_q.push_back(e);
        exp_wr++;
        model_sbe = (model_sbe == 15) ? 15 : model_sbe + 1;
      end else if (nerr >= 2) begin
        e = '{K_DBE, a, '0, '0};
        exp_q.push_back(e);
        model_dbe = (model_dbe == 15) ? 15 : model_dbe + 1;
        model_dbe_addr = a;
      end
      if (a == clr_at) begin model_sbe = 0; model_dbe = 0; end
      if (a == abort_at) break;
    end
    if (abort_at < 0) begin
      e = '{K_DONE, 0, '0, '0};
      exp_q.push_back(e);
      exp_dn = 1;
    end
    stall_armed = (abort_at >= 0);
    clr_addr = clr_at;
    clr_armed = (clr_at >= 0);
    pulse_start();
    wait_idle({tag, "_idle"});
    repeat (2) @(negedge clk);
    check({tag, "_queue_empty"}, 96'(exp_q.size()), 96'(0));
    check({tag, "_reads"}, 96'(rd_seen - rd0), 96'(exp_rd));
    check({tag, "_writes"}, 96'(wr_seen - wr0), 96'(exp_wr));
    check({tag, "_done"}, 96'(done_seen - dn0), 96'(exp_dn));
    check({tag, "_sbe_cnt"}, 96'(sbe_cnt), 96'(model_sbe));
    check({tag, "_dbe_cnt"}, 96'(dbe_cnt), 96'(model_dbe));
    check({tag, "_dbe_addr"}, 96'(dbe_addr), 96'(model_dbe_addr));
    exp_q.delete();
    $display("[TB] pass %s: reads=%0d writes=%0d sbe=%0d dbe=%0d", tag, rd_seen - rd0, wr_seen - wr0,
             sbe_cnt, dbe_cnt);
  endtask

  initial begin : stimulus
    int base, nb, b0, b1, bad;
    rst = 1'b1; start = 1'b0;
    init_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 96'({mem_req, mem_we, busy, done, dbe_irq}), 96'(0));
    check("rst_addr", 96'(mem_addr), 96'(0));
    check("rst_wdata", 96'(mem_wdata), 96'(0));
    check("rst_wparity", 96'(mem_wparity), 96'(0));
    check("rst_cnt", 96'({sbe_cnt, dbe_cnt}), 96'(0));
    check("rst_dbe_addr", 96'(dbe_addr), 96'(0));
    @(posedge clk); #1 rst = 1'b0;

    run_pass("clean", -1, -1);
    flip_bit(3, 5);
    run_pass("sbe_data", -1, -1);
    check("addr3_repaired", 96'({mem_d[3], mem_p[3]}), 96'({orig_d[3], orig_p[3]}));
    run_pass("rescan", -1, -1);
    flip_bit(7, 72 + 2);
    run_pass("sbe_parity", -1, -1);
    flip_bit(9, 0);
    flip_bit(9, 1);
    run_pass("dbe", -1, -1);
    mem_d[9] = orig_d[9];

    for (int r = 0; r < 4; r++) begin
      base = $urandom_range(0, NW - 1);
      for (int k = 0; k < 4; k++) begin
        nb = $urandom_range(1, 2);
        b0 = $urandom_range(0, 79);
        b1 = (b0 + $urandom_range(1, 79)) % 80;
        flip_bit((base + k * 4) % NW, b0);
        if (nb == 2) flip_bit((base + k * 4) % NW, b1);
      end
      run_pass("random", -1, -1);
      for (int a = 0; a < NW; a++) begin mem_d[a] = orig_d[a]; mem_p[a] = orig_p[a]; end
    end

    flip_bit(2, 40);
    run_pass("abort_wr", 2, -1);

    for (int a = 0; a < NW; a++) flip_bit(a, $urandom_range(0, 79));
    run_pass("saturate", -1, -1);
    flip_bit(5, 11);
    run_pass("clr_vs_sbe", -1, 5);
    flip_bit(6, 77);
    run_pass("count_resume", -1, -1);

    // Reset in the middle of a pass.
    mon_en = 1'b0;
    flip_bit(0, 20);
    pulse_start();
    repeat (25) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_busy_req", 96'({busy, mem_req}), 96'(0));
    check("midrst_cnt", 96'({sbe_cnt, dbe_cnt}), 96'(0));
    check("midrst_dbe_addr", 96'(dbe_addr), 96'(0));
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    model_sbe = 0; model_dbe = 0; model_dbe_addr = 0;
    init_mem();
    @(negedge clk);
    mon_en = 1'b1;
    run_pass("after_rst", -1, -1);

    bad = 0;
    for (int a = 0; a < NW; a++) if ({mem_d[a], mem_p[a]} !== {orig_d[a], orig_p[a]}) bad++;
    check("final_mem_clean", 96'(bad), 96'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
